// File: rtl/if_prefetch_pkg.sv
// ============================================================================
// if_prefetch_pkg - shared fetch constants, the buffered entry type and a PC helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_prefetch_pkg;

  localparam logic [31:0] C_INST_NOP = 32'h0000_0013;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Jump targets are forced onto a word boundary
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fifo.sv
// ============================================================================
// if_fifo - DEPTH-entry synchronous FIFO with flush and a separate entry count
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally; count alone tells full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch - fetch PC generation, ROM addressing and {pc,inst} buffering to decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter logic [31:0] NOP_INST = C_INST_NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            rom_addr_o,
  input  logic [31:0]            rom_data_i,
  input  logic                   jump_en_i,
  input  logic [31:0]            jump_addr_i,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [31:0]            inst_o,
  output logic [31:0]            inst_addr_o,
  output logic [$clog2(DEPTH):0] fill_o
);

  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;

  assign w_pop  = inst_valid_o & inst_ready_i;
  // A full buffer still accepts a word when the head leaves in the same cycle
  assign w_push = ~jump_en_i & (~w_full | w_pop);

  always_comb begin
    w_wr_entry.pc   = fetch_pc_q;
    w_wr_entry.inst = rom_data_i;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (jump_en_i)   fetch_pc_d = align_pc(jump_addr_i);
    else if (w_push) fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_pc_q <= RESET_PC;
    else      fetch_pc_q <= fetch_pc_d;
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (jump_en_i),
    .data_i  (w_wr_entry),
    .data_o  (w_head),
    .count_o (fill_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign rom_addr_o   = fetch_pc_q;
  assign inst_valid_o = ~w_empty;
  assign inst_o       = inst_valid_o ? w_head.inst : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? w_head.pc   : 32'h0;

endmodule

`default_nettype wire
